mod_reduct_mersenne_arb: RTL and testbench

- Shares one Mersenne reduction core (z = a mod 2^MOD_W-1, internal IN_PIPE=IN_PIPE, one output pipe stage, SIDE_W carries requester id) between NB_REQ requesters.
- Round-robin arbitration on a valid/ready input interface.
- Credit-based flow control: the core has no backpressure, so each requester gets a private output FIFO whose space is reserved at grant time.
- Sits between NTT/accumulate lanes and the shared reduction resource.

---
 rtl/mod_reduct_mersenne_arb.sv | 210 +++++++++++++++++++++
 tb/tb_mod_reduct_mersenne_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduct_mersenne_arb.sv
// Shares one Mersenne (2^MOD_W-1) reduction core between NB_REQ requesters, with credit-reserved output FIFOs.
// Round-robin by default; define MOD_REDUCT_ARB_STRICT_PRIO_EN for fixed lowest-index priority.
module mod_reduct_mersenne_arb #(
  parameter int MOD_W     = 33,
  parameter int OP_W      = 67,
  parameter int NB_REQ    = 4,
  parameter int OUT_DEPTH = 4,
  parameter int IN_PIPE   = 1
) (
  input  logic                    clk,
  input  logic                    s_rst_n,
  input  logic [NB_REQ*OP_W-1:0]  in_a,
  input  logic [NB_REQ-1:0]       in_vld,
  output logic [NB_REQ-1:0]       in_rdy,
  output logic [NB_REQ*MOD_W-1:0] out_z,
  output logic [NB_REQ-1:0]       out_vld,
  input  logic [NB_REQ-1:0]       out_rdy,
  output logic                    busy
);

  localparam int ID_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CRD_W = $clog2(OUT_DEPTH + 1);
  localparam int FP_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int EXT_W = 2*MOD_W + 2;
  localparam int S1_W  = MOD_W + 2;
  localparam int S2_W  = MOD_W + 1;

  // Three folds bound the sum below 2^MOD_W; the all-ones residue is the second encoding of zero.
  function automatic logic [MOD_W-1:0] mersenne_reduce(input logic [OP_W-1:0] a);
    logic [EXT_W-1:0] v_ext;
    logic [S1_W-1:0]  v_s1;
    logic [S2_W-1:0]  v_s2;
    logic [MOD_W-1:0] v_s3;
    v_ext = EXT_W'(a);
    v_s1  = S1_W'(v_ext[MOD_W-1:0]) + S1_W'(v_ext[2*MOD_W-1:MOD_W]) + S1_W'(v_ext[EXT_W-1:2*MOD_W]);
    v_s2  = S2_W'(v_s1[MOD_W-1:0]) + S2_W'(v_s1[S1_W-1:MOD_W]);
    v_s3  = v_s2[MOD_W-1:0] + MOD_W'(v_s2[MOD_W]);
    return (v_s3 == {MOD_W{1'b1}}) ? '0 : v_s3;
  endfunction

  function automatic logic [FP_W-1:0] fifo_next(input logic [FP_W-1:0] p);
    return (p == FP_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [OP_W-1:0]  w_a_arr [NB_REQ];
  logic [NB_REQ-1:0] w_elig, w_acc, w_push, w_pop;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_idx;

  logic [CRD_W-1:0]  r_credit [NB_REQ];
  logic [CRD_W-1:0]  r_cnt    [NB_REQ];
  logic [FP_W-1:0]   r_wp     [NB_REQ];
  logic [FP_W-1:0]   r_rp     [NB_REQ];
  logic [MOD_W-1:0]  r_mem    [NB_REQ][OUT_DEPTH];

  logic              r_d_avail, r_o_avail, r_busy;
  logic [OP_W-1:0]   r_d_a;
  logic [ID_W-1:0]   r_d_side, r_o_side;
  logic [MOD_W-1:0]  r_o_z;
  logic              w_c_avail;
  logic [OP_W-1:0]   w_c_a;
  logic [ID_W-1:0]   w_c_side;

  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      w_a_arr[i] = in_a[i*OP_W +: OP_W];
      w_elig[i]  = in_vld[i] && (r_credit[i] != '0);
    end
  end

`ifdef MOD_REDUCT_ARB_STRICT_PRIO_EN
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;

  // Descending scan so the candidate closest to the pointer is the last, winning, assignment.
  always_comb begin
    int v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    v_idx     = 0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NB_REQ) v_idx = v_idx - NB_REQ;
      if (w_elig[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'(v_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) r_ptr <= '0;
    else if (w_gnt_vld) r_ptr <= (w_gnt_idx == ID_W'(NB_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  end
`endif

  always_comb begin
    in_rdy  = '0;
    w_acc   = '0;
    w_push  = '0;
    out_vld = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      in_rdy[i]  = w_gnt_vld && (w_gnt_idx == ID_W'(i));
      w_acc[i]   = w_gnt_vld && (w_gnt_idx == ID_W'(i)) && in_vld[i];
      w_push[i]  = r_o_avail && (r_o_side == ID_W'(i));
      out_vld[i] = (r_cnt[i] != '0);
    end
  end

  always_comb begin
    w_pop = '0;
    out_z = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      w_pop[i] = out_vld[i] && out_rdy[i];
      out_z[i*MOD_W +: MOD_W] = out_vld[i] ? r_mem[i][r_rp[i]] : '0;
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_d_avail <= 1'b0;
      r_d_a     <= '0;
      r_d_side  <= '0;
    end else begin
      r_d_avail <= |w_acc;
      r_d_a     <= w_a_arr[w_gnt_idx];
      r_d_side  <= w_gnt_idx;
    end
  end

  generate
    if (IN_PIPE != 0) begin : g_in_pipe
      logic            r_c_avail;
      logic [OP_W-1:0] r_c_a;
      logic [ID_W-1:0] r_c_side;
      always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
          r_c_avail <= 1'b0;
          r_c_a     <= '0;
          r_c_side  <= '0;
        end else begin
          r_c_avail <= r_d_avail;
          r_c_a     <= r_d_a;
          r_c_side  <= r_d_side;
        end
      end
      assign w_c_avail = r_c_avail;
      assign w_c_a     = r_c_a;
      assign w_c_side  = r_c_side;
    end else begin : g_no_in_pipe
      assign w_c_avail = r_d_avail;
      assign w_c_a     = r_d_a;
      assign w_c_side  = r_d_side;
    end
  endgenerate

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_o_avail <= 1'b0;
      r_o_z     <= '0;
      r_o_side  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_o_avail <= w_c_avail;
      r_o_z     <= mersenne_reduce(w_c_a);
      r_o_side  <= w_c_side;
      r_busy    <= (|w_acc) || r_d_avail || w_c_avail || r_o_avail || (|out_vld);
    end
  end

  // Credit is taken at grant and returned at pop, so a push never meets a full FIFO.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < NB_REQ; i++) begin
        r_credit[i] <= CRD_W'(OUT_DEPTH);
        r_cnt[i]    <= '0;
        r_wp[i]     <= '0;
        r_rp[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NB_REQ; i++) begin
        if (w_acc[i] && !w_pop[i]) r_credit[i] <= r_credit[i] - 1'b1;
        else if (!w_acc[i] && w_pop[i]) r_credit[i] <= r_credit[i] + 1'b1;
        if (w_push[i] && !w_pop[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
        if (w_push[i]) r_wp[i] <= fifo_next(r_wp[i]);
        if (w_pop[i]) r_rp[i] <= fifo_next(r_rp[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_REQ; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i]] <= r_o_z;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_mod_reduct_mersenne_arb.sv
// Directed bench for mod_reduct_mersenne_arb: per-requester scoreboard fed by an independent % model,
// plus hand-computed checks of latency, grant order, credit blocking, reset flush and boundary operands.
module tb_mod_reduct_mersenne_arb;

  localparam int M   = 33;
  localparam int OPW = 67;
  localparam int NB  = 4;
  localparam int OD  = 4;
  localparam logic [OPW:0]   MODV = {{(OPW + 1 - M){1'b0}}, {M{1'b1}}};
  localparam logic [OPW-1:0] ALL1 = {OPW{1'b1}};

  logic              clk = 1'b0;
  logic              s_rst_n;
  logic [NB*OPW-1:0] in_a;
  logic [NB-1:0]     in_vld;
  logic [NB-1:0]     in_rdy;
  logic [NB*M-1:0]   out_z;
  logic [NB-1:0]     out_vld;
  logic [NB-1:0]     out_rdy;
  logic              busy;

  always #5 clk = ~clk;

  mod_reduct_mersenne_arb #(
    .MOD_W(M), .OP_W(OPW), .NB_REQ(NB), .OUT_DEPTH(OD), .IN_PIPE(1)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n), .in_a(in_a), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_z(out_z), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy)
  );

  int             vectors = 0;
  int             miscompares = 0;
  logic [M-1:0]   expQ [NB][$];
  int             gntLog [$];
  int             accCnt [NB];
  logic [NB-1:0]  lastAcc, lastPop;
  int             expOrder [8];

  function automatic logic [M-1:0] refMod(input logic [OPW-1:0] a);
    logic [OPW:0] r;
    r = {1'b0, a} % MODV;
    return r[M-1:0];
  endfunction

  function automatic logic [OPW-1:0] randOperand();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return ALL1;
      1: return OPW'({M{1'b1}});
      2: return '0;
      3: return OPW'(raw[M:0]);
      default: return raw[OPW-1:0];
    endcase
  endfunction

  function automatic bit pendingAny();
    for (int i = 0; i < NB; i++) if (expQ[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] vld, input logic [NB-1:0] rdy);
    in_vld  = vld;
    out_rdy = rdy;
  endtask

  task automatic setA(input int i, input logic [OPW-1:0] a);
    in_a[i*OPW +: OPW] = a;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < NB; i++) accCnt[i] = 0;
    gntLog.delete();
  endtask

  // Sample handshakes mid-cycle, settle scoreboard, then advance to just after the next rising edge.
  task automatic tick();
    logic [M-1:0] z;
    @(negedge clk);
    lastAcc = in_vld & in_rdy;
    lastPop = out_vld & out_rdy;
    checkOutput("rdy_onehot0", 128'($onehot0(in_rdy)), 128'(1));
    for (int i = 0; i < NB; i++) begin
      if (lastPop[i]) begin
        z = out_z[i*M +: M];
        if (expQ[i].size() == 0) checkOutput($sformatf("unexpected_z_req%0d", i), 128'(out_vld[i]), 128'(0));
        else checkOutput($sformatf("z_req%0d", i), 128'(z), 128'(expQ[i].pop_front()));
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (lastAcc[i]) begin
        expQ[i].push_back(refMod(in_a[i*OPW +: OPW]));
        gntLog.push_back(i);
        accCnt[i]++;
        checkOutput($sformatf("outstanding_req%0d", i), 128'(expQ[i].size() <= OD), 128'(1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    in_vld  = '0;
    s_rst_n = 1'b0;
    for (int i = 0; i < NB; i++) expQ[i].delete();
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((pendingAny() || out_vld != '0) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", 128'(n < 300), 128'(1));
  endtask

  task automatic directed0(input string tag, input logic [OPW-1:0] a, input logic [M-1:0] expZ);
    setA(0, a);
    applyStimulus(4'b0001, 4'b1111);
    tick();
    checkOutput({tag, "_acc"}, 128'(lastAcc), 128'(4'b0001));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(1));
    applyStimulus(4'b0000, 4'b1111);
    tick();
    checkOutput({tag, "_vld_c1"}, 128'(out_vld[0]), 128'(0));
    tick();
    checkOutput({tag, "_vld_c2"}, 128'(out_vld[0]), 128'(0));
    tick();
    checkOutput({tag, "_vld_c3"}, 128'(out_vld[0]), 128'(1));
    checkOutput({tag, "_z"}, 128'(out_z[M-1:0]), 128'(expZ));
  endtask

  initial begin
    int total;
    int cyc;
    logic [NB-1:0] pending;
    logic [OPW-1:0] opTab [4];
`ifdef MOD_REDUCT_ARB_STRICT_PRIO_EN
    expOrder = '{0, 0, 0, 0, 1, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    opTab[0] = ALL1;
    opTab[1] = OPW'(34'h1_FFFF_FFFE);
    opTab[2] = OPW'(1) << 66;
    opTab[3] = 67'h1_2345_6789_ABCD_EF01;

    s_rst_n = 1'b0;
    in_a    = '0;
    in_vld  = '0;
    out_rdy = '0;
    #1;
    checkOutput("rst_in_rdy", 128'(in_rdy), 128'(0));
    checkOutput("rst_out_vld", 128'(out_vld), 128'(0));
    checkOutput("rst_out_z_zero", 128'(out_z == '0), 128'(1));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;

    $display("[TB] single requester latency and arithmetic");
    directed0("mersenne", OPW'({M{1'b1}}), 33'd0);
    directed0("all_ones", ALL1, 33'd1);
    directed0("pow66m1", {1'b0, {(OPW - 1){1'b1}}}, 33'd0);
    directed0("five", OPW'(5), 33'd5);
    applyStimulus(4'b0000, 4'b1111);
    waitIdle();

    $display("[TB] all requesters, grant order");
    applyReset();
    clearCounts();
    applyStimulus(4'b1111, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NB; i++) setA(i, opTab[(i + k) % 4]);
      tick();
    end
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("grant_count", 128'(gntLog.size()), 128'(8));
    for (int k = 0; k < 8 && k < gntLog.size(); k++)
      checkOutput($sformatf("grant_%0d", k), 128'(gntLog[k]), 128'(expOrder[k]));
    waitIdle();

    $display("[TB] credit blocking on requester 1");
    applyReset();
    clearCounts();
    setA(1, 67'h5_5555_5555_5555_5555);
    setA(2, 67'h2_AAAA_AAAA_AAAA_AAAA);
    applyStimulus(4'b0110, 4'b1101);
    repeat (16) tick();
    checkOutput("blocked_acc1", 128'(accCnt[1]), 128'(4));
    checkOutput("blocked_acc2_progress", 128'(accCnt[2] >= 6), 128'(1));
    checkOutput("blocked_in_rdy1", 128'(in_rdy[1]), 128'(0));
    checkOutput("blocked_out_vld1", 128'(out_vld[1]), 128'(1));
    applyStimulus(4'b0110, 4'b1111);
    tick();
    checkOutput("full_pop1", 128'(lastPop[1]), 128'(1));
    checkOutput("full_pop_no_acc1", 128'(lastAcc[1]), 128'(0));
    applyStimulus(4'b0110, 4'b1101);
    tick();
    checkOutput("credit_return_acc1", 128'(lastAcc[1]), 128'(1));
    clearCounts();
    repeat (6) tick();
    checkOutput("reblocked_acc1", 128'(accCnt[1]), 128'(0));
    checkOutput("reblocked_acc2_progress", 128'(accCnt[2] >= 3), 128'(1));
    applyStimulus(4'b0000, 4'b1111);
    waitIdle();

    $display("[TB] reset mid-operation");
    applyReset();
    clearCounts();
    setA(0, opTab[3]);
    setA(1, opTab[0]);
    applyStimulus(4'b0011, 4'b0000);
    repeat (5) tick();
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("pre_rst_accepts", 128'(accCnt[0] + accCnt[1]), 128'(5));
`ifdef MOD_REDUCT_ARB_STRICT_PRIO_EN
    checkOutput("pre_rst_out_vld", 128'(out_vld), 128'(4'b0001));
`else
    checkOutput("pre_rst_out_vld", 128'(out_vld), 128'(4'b0011));
`endif
    checkOutput("pre_rst_busy", 128'(busy), 128'(1));
    s_rst_n = 1'b0;
    for (int i = 0; i < NB; i++) expQ[i].delete();
    #1;
    checkOutput("mid_rst_out_vld", 128'(out_vld), 128'(0));
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    checkOutput("mid_rst_in_rdy", 128'(in_rdy), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b1111);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("no_stale_%0d", k), 128'(out_vld), 128'(0));
    end
    clearCounts();
    for (int i = 0; i < NB; i++) setA(i, opTab[i]);
    applyStimulus(4'b1111, 4'b0000);
    tick();
    checkOutput("post_rst_first_grant", 128'((gntLog.size() > 0) ? gntLog[0] : -1), 128'(0));
    repeat (19) tick();
    for (int i = 0; i < NB; i++)
      checkOutput($sformatf("post_rst_credits_req%0d", i), 128'(accCnt[i]), 128'(OD));
    applyStimulus(4'b0000, 4'b1111);
    waitIdle();

    $display("[TB] all-ones operand on every requester");
    for (int i = 0; i < NB; i++) setA(i, ALL1);
    pending = 4'b1111;
    out_rdy = 4'b0000;
    for (int k = 0; k < 20 && pending != '0; k++) begin
      in_vld = pending;
      tick();
      pending = pending & ~lastAcc;
    end
    in_vld = '0;
    for (int k = 0; k < 20 && out_vld != 4'b1111; k++) tick();
    checkOutput("ones_out_vld", 128'(out_vld), 128'(4'b1111));
    for (int i = 0; i < NB; i++)
      checkOutput($sformatf("ones_z_req%0d", i), 128'(out_z[i*M +: M]), 128'(33'd1));
    applyStimulus(4'b0000, 4'b1111);
    waitIdle();

    $display("[TB] random operands with random backpressure");
    total = 0;
    cyc   = 0;
    while (total < 10000 && cyc < 40000) begin
      for (int i = 0; i < NB; i++) begin
        setA(i, randOperand());
        in_vld[i]  = ($urandom_range(0, 3) != 0);
        out_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
      total += $countones(lastAcc);
      cyc++;
    end
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("random_accepts", 128'(total), 128'(10000));
    waitIdle();
    tick();
    tick();
    checkOutput("final_busy", 128'(busy), 128'(0));
    checkOutput("final_out_vld", 128'(out_vld), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
